// File: rtl/axi4_slave_pkg.sv
// Shared constants and FSM state types for the AXI4 slave memory.
package axi4_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] SIZE_8B     = 3'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;
endpackage

// File: rtl/axi4_slave_addr_gen.sv
// Next-beat address and burst legality for one AXI channel.
// AXI_SLV_WRAP_EN enables WRAP bursts; otherwise WRAP is flagged as an error.
module axi4_slave_addr_gen #(
  parameter int adr_wid = 32
) (
  input  logic [adr_wid-1:0] i_addr,
  input  logic [7:0]         i_len,
  input  logic [1:0]         i_burst,
  input  logic [2:0]         i_size,
  output logic [adr_wid-1:0] o_next,
  output logic               o_err
);
  import axi4_slave_pkg::*;

  logic [adr_wid-1:0] w_inc;
  assign w_inc = i_addr + adr_wid'(8);

`ifdef AXI_SLV_WRAP_EN
  logic [adr_wid-1:0] w_mask;
  logic               w_len_ok;
  // For legal wrap lengths (len+1)*8-1 is simply {len, 3'b111}
  assign w_mask   = adr_wid'({i_len[3:0], 3'b111});
  assign w_len_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
`else
  logic w_len_unused;
  assign w_len_unused = ^i_len;
`endif

  always_comb begin
    o_next = w_inc;
    o_err  = (i_size != SIZE_8B);
    case (i_burst)
      BURST_FIXED: o_next = i_addr;
      BURST_INCR:  o_next = w_inc;
`ifdef AXI_SLV_WRAP_EN
      BURST_WRAP: begin
        o_next = (i_addr & ~w_mask) | (w_inc & w_mask);
        o_err  = o_err | ~w_len_ok;
      end
`endif
      default:     o_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a 64-bit word memory; independent read and write FSMs.
// Optional WRAP burst support under AXI_SLV_WRAP_EN.
module axi4_slave_mem #(
  parameter int data_wid  = 64,
  parameter int adr_wid   = 32,
  parameter int id_wid    = 8,
  parameter int mem_depth = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [id_wid-1:0]     AWID_a,
  input  logic [adr_wid-1:0]    AWADDR_a,
  input  logic [7:0]            AWLEN_a,
  input  logic [2:0]            AWSIZE_a,
  input  logic [1:0]            AWBURST_a,
  input  logic                  AWVALID_a,
  input  logic [1:0]            AWLOCK_a,
  input  logic [1:0]            AWCACHE_a,
  input  logic [2:0]            AWPROT_a,
  output logic                  AWREADY_a,
  input  logic [id_wid-1:0]     WID_a,
  input  logic [data_wid-1:0]   WDATA_a,
  input  logic [data_wid/8-1:0] WSTRB_a,
  input  logic                  WLAST_a,
  input  logic                  WVALID_a,
  output logic                  WREADY_a,
  output logic [id_wid-1:0]     BID_a,
  output logic [1:0]            BRESP_a,
  output logic                  BVALID_a,
  input  logic                  BREADY_a,
  input  logic [id_wid-1:0]     ARID_a,
  input  logic [adr_wid-1:0]    ARADDR_a,
  input  logic [7:0]            ARLEN_a,
  input  logic [2:0]            ARSIZE_a,
  input  logic [1:0]            ARBURST_a,
  input  logic                  ARVALID_a,
  input  logic [1:0]            ARLOCK_a,
  input  logic [1:0]            ARCACHE_a,
  input  logic [2:0]            ARPROT_a,
  output logic                  ARREADY_a,
  output logic [id_wid-1:0]     RID_a,
  output logic [data_wid-1:0]   RDATA_a,
  output logic [1:0]            RRESP_a,
  output logic                  RLAST_a,
  output logic                  RVALID_a,
  input  logic                  RREADY_a
);
  import axi4_slave_pkg::*;

  localparam int IDX_W   = $clog2(mem_depth);
  localparam int IDX_MSB = IDX_W + 2;

  logic [data_wid-1:0] r_mem [mem_depth];

  logic w_sideband_unused;
  assign w_sideband_unused = ^{AWLOCK_a, AWCACHE_a, AWPROT_a, ARLOCK_a, ARCACHE_a, ARPROT_a, WID_a};

  // ---------------- write channel ----------------
  wr_state_e           r_wstate, w_wnext;
  logic                r_awready, r_wready, r_bvalid, r_wlast_err;
  logic [1:0]          r_bresp, r_awburst;
  logic [2:0]          r_awsize;
  logic [7:0]          r_awlen, r_wbeat;
  logic [id_wid-1:0]   r_awid, r_bid;
  logic [adr_wid-1:0]  r_waddr, w_wnaddr;
  logic [IDX_W-1:0]    w_widx;
  logic                w_werr, w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat;

  assign w_aw_hs      = r_awready & AWVALID_a;
  assign w_w_hs       = r_wready & WVALID_a;
  assign w_b_hs       = r_bvalid & BREADY_a;
  assign w_wlast_beat = (r_wbeat == r_awlen);
  assign w_widx       = r_waddr[IDX_MSB:3];

  axi4_slave_addr_gen #(.adr_wid(adr_wid)) u_wgen (
    .i_addr(r_waddr), .i_len(r_awlen), .i_burst(r_awburst), .i_size(r_awsize),
    .o_next(w_wnaddr), .o_err(w_werr)
  );

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wnext = W_RESP;
      W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  // Ready/valid are registered from next state so they stay low throughout reset
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_bid       <= '0;
      r_awid      <= '0;
      r_waddr     <= '0;
      r_awlen     <= '0;
      r_awburst   <= BURST_FIXED;
      r_awsize    <= '0;
      r_wbeat     <= '0;
      r_wlast_err <= 1'b0;
    end else begin
      r_wstate  <= w_wnext;
      r_awready <= (w_wnext == W_IDLE);
      r_wready  <= (w_wnext == W_DATA);
      r_bvalid  <= (w_wnext == W_RESP);
      if (w_aw_hs) begin
        r_awid      <= AWID_a;
        r_waddr     <= AWADDR_a;
        r_awlen     <= AWLEN_a;
        r_awburst   <= AWBURST_a;
        r_awsize    <= AWSIZE_a;
        r_wbeat     <= '0;
        r_wlast_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_waddr <= w_wnaddr;
        r_wbeat <= r_wbeat + 8'd1;
        if (WLAST_a != w_wlast_beat) r_wlast_err <= 1'b1;
        if (w_wlast_beat) begin
          r_bid   <= r_awid;
          r_bresp <= (w_werr || r_wlast_err || !WLAST_a) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_w_hs && !w_werr)
      for (int b = 0; b < data_wid/8; b++)
        if (WSTRB_a[b]) r_mem[w_widx][8*b +: 8] <= WDATA_a[8*b +: 8];
  end

  // ---------------- read channel ----------------
  rd_state_e           r_rstate, w_rnext;
  logic                r_arready, r_rvalid, r_rlast;
  logic [1:0]          r_rresp, r_arburst, w_rg_burst;
  logic [2:0]          r_arsize, w_rg_size;
  logic [7:0]          r_arlen, r_rbeat, w_rg_len;
  logic [id_wid-1:0]   r_rid;
  logic [data_wid-1:0] r_rdata;
  logic [adr_wid-1:0]  r_raddr, w_rg_addr, w_rnaddr;
  logic                w_rerr, w_ar_hs, w_r_hs;

  assign w_ar_hs = r_arready & ARVALID_a;
  assign w_r_hs  = r_rvalid & RREADY_a;

  // While idle the generator looks at the incoming AR request; r_raddr then
  // always holds the address of the next beat to fetch.
  assign w_rg_addr  = r_arready ? ARADDR_a  : r_raddr;
  assign w_rg_len   = r_arready ? ARLEN_a   : r_arlen;
  assign w_rg_burst = r_arready ? ARBURST_a : r_arburst;
  assign w_rg_size  = r_arready ? ARSIZE_a  : r_arsize;

  axi4_slave_addr_gen #(.adr_wid(adr_wid)) u_rgen (
    .i_addr(w_rg_addr), .i_len(w_rg_len), .i_burst(w_rg_burst), .i_size(w_rg_size),
    .o_next(w_rnaddr), .o_err(w_rerr)
  );

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arburst <= BURST_FIXED;
      r_arsize  <= '0;
      r_rbeat   <= '0;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= (w_rnext == R_IDLE);
      if (w_ar_hs) begin
        r_rid     <= ARID_a;
        r_arlen   <= ARLEN_a;
        r_arburst <= ARBURST_a;
        r_arsize  <= ARSIZE_a;
        r_raddr   <= w_rnaddr;
        r_rbeat   <= '0;
        r_rvalid  <= 1'b1;
        r_rlast   <= (ARLEN_a == 8'd0);
        r_rresp   <= w_rerr ? RESP_SLVERR : RESP_OKAY;
        r_rdata   <= w_rerr ? '0 : r_mem[ARADDR_a[IDX_MSB:3]];
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rvalid <= 1'b0;
          r_rlast  <= 1'b0;
        end else begin
          r_rbeat <= r_rbeat + 8'd1;
          r_rlast <= ((r_rbeat + 8'd1) == r_arlen);
          r_raddr <= w_rnaddr;
          r_rdata <= (r_rresp == RESP_SLVERR) ? '0 : r_mem[r_raddr[IDX_MSB:3]];
        end
      end
    end
  end

  assign AWREADY_a = r_awready;
  assign WREADY_a  = r_wready;
  assign BVALID_a  = r_bvalid;
  assign BRESP_a   = r_bresp;
  assign BID_a     = r_bid;
  assign ARREADY_a = r_arready;
  assign RVALID_a  = r_rvalid;
  assign RLAST_a   = r_rlast;
  assign RRESP_a   = r_rresp;
  assign RID_a     = r_rid;
  assign RDATA_a   = r_rdata;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomized bench for axi4_slave_mem against a word-array reference model.
module tb_axi4_slave_mem;
  localparam int DEPTH = 64;
  localparam int LIM   = 200;
`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic [7:0]  AWID_a, WID_a, BID_a, ARID_a, RID_a;
  logic [31:0] AWADDR_a, ARADDR_a;
  logic [7:0]  AWLEN_a, ARLEN_a, WSTRB_a;
  logic [2:0]  AWSIZE_a, ARSIZE_a, AWPROT_a, ARPROT_a;
  logic [1:0]  AWBURST_a, ARBURST_a, AWLOCK_a, AWCACHE_a, ARLOCK_a, ARCACHE_a, BRESP_a, RRESP_a;
  logic        AWVALID_a, AWREADY_a, WLAST_a, WVALID_a, WREADY_a, BVALID_a, BREADY_a;
  logic        ARVALID_a, ARREADY_a, RLAST_a, RVALID_a, RREADY_a;
  logic [63:0] WDATA_a, RDATA_a;

  axi4_slave_mem #(.data_wid(64), .adr_wid(32), .id_wid(8), .mem_depth(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_a(AWID_a), .AWADDR_a(AWADDR_a), .AWLEN_a(AWLEN_a), .AWSIZE_a(AWSIZE_a),
    .AWBURST_a(AWBURST_a), .AWVALID_a(AWVALID_a), .AWLOCK_a(AWLOCK_a), .AWCACHE_a(AWCACHE_a),
    .AWPROT_a(AWPROT_a), .AWREADY_a(AWREADY_a),
    .WID_a(WID_a), .WDATA_a(WDATA_a), .WSTRB_a(WSTRB_a), .WLAST_a(WLAST_a), .WVALID_a(WVALID_a),
    .WREADY_a(WREADY_a), .BID_a(BID_a), .BRESP_a(BRESP_a), .BVALID_a(BVALID_a), .BREADY_a(BREADY_a),
    .ARID_a(ARID_a), .ARADDR_a(ARADDR_a), .ARLEN_a(ARLEN_a), .ARSIZE_a(ARSIZE_a),
    .ARBURST_a(ARBURST_a), .ARVALID_a(ARVALID_a), .ARLOCK_a(ARLOCK_a), .ARCACHE_a(ARCACHE_a),
    .ARPROT_a(ARPROT_a), .ARREADY_a(ARREADY_a),
    .RID_a(RID_a), .RDATA_a(RDATA_a), .RRESP_a(RRESP_a), .RLAST_a(RLAST_a), .RVALID_a(RVALID_a),
    .RREADY_a(RREADY_a)
  );

  always #5 ACLK = ~ACLK;

  int          n_chk = 0, n_fail = 0;
  logic [63:0] mdl  [DEPTH];
  logic [63:0] wdat [16];
  logic [7:0]  wstb [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit bad(input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
    if (size != 3'd3 || burst == 2'b11) return 1'b1;
    if (burst == 2'b10) return !WRAP_EN || !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return 1'b0;
  endfunction

  // Word touched by beat i, straight from the burst-type address rules
  function automatic int widx(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input int i);
    int unsigned a, bnd, base;
    case (burst)
      2'b00: a = addr;
      2'b10: begin
        bnd  = (int'(len) + 1) * 8;
        base = addr - addr % bnd;
        a    = base + (addr % bnd + 8 * i) % bnd;
      end
      default: a = addr + 8 * i;
    endcase
    return int'((a / 8) % DEPTH);
  endfunction

  task automatic axi_wr(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size, input int last_at);
    int n;
    bit e;
    logic [1:0] exp_resp;
    e = bad(burst, len, size);
    AWID_a = id; AWADDR_a = addr; AWLEN_a = len; AWBURST_a = burst; AWSIZE_a = size; AWVALID_a = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY_a && n < LIM) begin @(negedge ACLK); n++; end
    if (n >= LIM) chk("aw_timeout", AWREADY_a, 1);
    @(posedge ACLK); #1 AWVALID_a = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 2) == 0) begin @(posedge ACLK); #1; end
      WDATA_a = wdat[i]; WSTRB_a = wstb[i]; WLAST_a = (i == last_at); WVALID_a = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!WREADY_a && n < LIM) begin @(negedge ACLK); n++; end
      if (n >= LIM) chk("w_timeout", WREADY_a, 1);
      @(posedge ACLK); #1 WVALID_a = 1'b0; WLAST_a = 1'b0;
      if (!e)
        for (int b = 0; b < 8; b++)
          if (wstb[i][b]) mdl[widx(addr, len, burst, i)][8*b +: 8] = wdat[i][8*b +: 8];
    end
    exp_resp = (e || last_at != int'(len)) ? 2'b10 : 2'b00;
    n = 0;
    @(negedge ACLK);
    while (!BVALID_a && n < LIM) begin @(negedge ACLK); n++; end
    if (n >= LIM) chk("b_timeout", BVALID_a, 1);
    chk("bid", BID_a, id);
    chk("bresp", BRESP_a, exp_resp);
    repeat ($urandom_range(0, 2)) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("b_hold", {BVALID_a, BRESP_a, BID_a}, {1'b1, exp_resp, id});
    end
    @(posedge ACLK); #1 BREADY_a = 1'b1;
    @(posedge ACLK); #1 BREADY_a = 1'b0;
    chk("b_done", {BVALID_a, AWREADY_a}, 2'b01);
  endtask

  // mode: 0 random RREADY, 1 toggling starting low, 2 always ready
  task automatic axi_rd(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size, input int mode);
    int n, beat, c;
    bit e;
    logic [63:0] exp_d;
    e = bad(burst, len, size);
    ARID_a = id; ARADDR_a = addr; ARLEN_a = len; ARBURST_a = burst; ARSIZE_a = size; ARVALID_a = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY_a && n < LIM) begin @(negedge ACLK); n++; end
    if (n >= LIM) chk("ar_timeout", ARREADY_a, 1);
    @(posedge ACLK); #1 ARVALID_a = 1'b0;
    chk("r_lat", RVALID_a, 1);
    beat = 0; c = 0;
    while (beat <= int'(len) && c < LIM) begin
      RREADY_a = (mode == 2) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      @(negedge ACLK);
      exp_d = e ? 64'd0 : mdl[widx(addr, len, burst, beat)];
      chk("r_vld", RVALID_a, 1);
      chk("rdata", RDATA_a, exp_d);
      chk("r_side", {RID_a, RRESP_a, RLAST_a}, {id, (e ? 2'b10 : 2'b00), (beat == int'(len))});
      if (RREADY_a) beat++;
      c++;
      @(posedge ACLK); #1;
    end
    if (beat <= int'(len)) chk("r_beats", beat, int'(len) + 1);
    RREADY_a = 1'b0;
    chk("r_end", {RVALID_a, ARREADY_a}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1);
  end

  int          n, hs, la;
  logic [31:0] ra;
  logic [7:0]  rl, rid;
  logic [1:0]  rb;
  logic [2:0]  rs;

  initial begin
    {AWID_a, AWADDR_a, AWLEN_a, AWSIZE_a, AWBURST_a, AWVALID_a} = '0;
    {WID_a, WDATA_a, WSTRB_a, WLAST_a, WVALID_a, BREADY_a} = '0;
    {ARID_a, ARADDR_a, ARLEN_a, ARSIZE_a, ARBURST_a, ARVALID_a, RREADY_a} = '0;
    AWLOCK_a = 2'($urandom); AWCACHE_a = 2'($urandom); AWPROT_a = 3'($urandom);
    ARLOCK_a = 2'($urandom); ARCACHE_a = 2'($urandom); ARPROT_a = 3'($urandom);
    WID_a = 8'($urandom);

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_rdy", {AWREADY_a, WREADY_a, BVALID_a, ARREADY_a, RVALID_a, RLAST_a}, 0);
    chk("rst_resp", {BRESP_a, RRESP_a, BID_a, RID_a}, 0);
    chk("rst_rdata", RDATA_a, 0);
    @(negedge ACLK) ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("rdy_after_rst", {AWREADY_a, ARREADY_a, WREADY_a}, 3'b110);

    // Fill memory so the model and DUT start identical
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      axi_wr(8'(k), 32'(k * 128), 8'd15, 2'b01, 3'd3, 15);
    end

    // Basic INCR write/read, data 1..4
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
    axi_wr(8'd3, 32'h10, 8'd3, 2'b01, 3'd3, 3);
    axi_rd(8'd3, 32'h10, 8'd3, 2'b01, 3'd3, 2);

    // Byte strobes over a zeroed word 0
    wdat[0] = 64'd0; wstb[0] = 8'hFF;
    axi_wr(8'd1, 32'h0, 8'd0, 2'b01, 3'd3, 0);
    wdat[0] = '1; wstb[0] = 8'h0F;
    axi_wr(8'd1, 32'h0, 8'd0, 2'b01, 3'd3, 0);
    axi_rd(8'd1, 32'h0, 8'd0, 2'b01, 3'd3, 2);

    // Early WLAST, then toggled-RREADY len=7 read
    for (int i = 0; i < 16; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
    axi_wr(8'd2, 32'h100, 8'd3, 2'b01, 3'd3, 2);
    axi_rd(8'd4, 32'h100, 8'd7, 2'b01, 3'd3, 1);

    // WRAP len=3 from 0x18, then inspect words 0..3 via INCR
    for (int i = 0; i < 4; i++) wdat[i] = {$urandom, $urandom};
    axi_wr(8'd5, 32'h18, 8'd3, 2'b10, 3'd3, 3);
    axi_rd(8'd5, 32'h0, 8'd3, 2'b01, 3'd3, 2);
    axi_rd(8'd5, 32'h18, 8'd3, 2'b10, 3'd3, 0);

    // FIXED, bad size, reserved burst, address modulo
    for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'($urandom); end
    axi_wr(8'd6, 32'h40, 8'd3, 2'b00, 3'd3, 3);
    axi_rd(8'd6, 32'h40, 8'd2, 2'b00, 3'd3, 0);
    axi_wr(8'd7, 32'h48, 8'd1, 2'b01, 3'd2, 1);
    axi_rd(8'd7, 32'h48, 8'd1, 2'b01, 3'd3, 2);
    axi_rd(8'd8, 32'h48, 8'd2, 2'b01, 3'd1, 2);
    axi_rd(8'd9, 32'h48, 8'd3, 2'b11, 3'd3, 0);
    for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
    axi_wr(8'd10, 32'h1F0, 8'd3, 2'b01, 3'd3, 3);
    axi_rd(8'd11, 32'h3F0, 8'd3, 2'b01, 3'd3, 0);

    // Concurrent read and write on distinct words
    for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
    fork
      axi_wr(8'd12, 32'h80, 8'd3, 2'b01, 3'd3, 3);
      axi_rd(8'd13, 32'hC0, 8'd5, 2'b01, 3'd3, 0);
    join

    for (int t = 0; t < 40; t++) begin
      rb = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 2)) : 3'd3;
      case ($urandom_range(0, 4))
        0: rl = 8'd1;
        1: rl = 8'd3;
        2: rl = 8'd7;
        3: rl = 8'd15;
        default: rl = 8'($urandom_range(0, 15));
      endcase
      ra  = 32'($urandom_range(0, 511)) << 3;
      rid = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wdat[i] = {$urandom, $urandom};
          wstb[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        end
        la = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(rl))) : int'(rl);
        axi_wr(rid, ra, rl, rb, rs, la);
      end else begin
        axi_rd(rid, ra, rl, rb, rs, int'($urandom_range(0, 2)));
      end
    end

    // Reset during beat 2 of a len=7 read
    ARID_a = 8'd7; ARADDR_a = 32'h40; ARLEN_a = 8'd7; ARBURST_a = 2'b01; ARSIZE_a = 3'd3; ARVALID_a = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY_a && n < LIM) begin @(negedge ACLK); n++; end
    if (n >= LIM) chk("ar_timeout", ARREADY_a, 1);
    @(posedge ACLK); #1 ARVALID_a = 1'b0; RREADY_a = 1'b1;
    n = 0; hs = 0;
    while (hs < 2 && n < LIM) begin
      @(negedge ACLK);
      if (RVALID_a && RREADY_a) hs++;
      n++;
    end
    if (hs < 2) chk("rst_beats", hs, 2);
    @(posedge ACLK); #1 ARESETn = 1'b0;
    #1;
    chk("rst_mid", {RVALID_a, RLAST_a, ARREADY_a, AWREADY_a}, 0);
    chk("rst_mid_rdata", RDATA_a, 0);
    RREADY_a = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("rdy_release", {ARREADY_a, AWREADY_a, RVALID_a}, 3'b110);
    axi_rd(8'd7, 32'h40, 8'd7, 2'b01, 3'd3, 2);
    axi_rd(8'd8, 32'h0, 8'd15, 2'b01, 3'd3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter data_wid, default 64, meaning data bus width; only 64 is supported.
REQ-002 SHALL have parameter adr_wid, default 32, meaning address width.
REQ-003 SHALL have parameter id_wid, default 8, meaning transaction ID width.
REQ-004 SHALL have parameter mem_depth, default 256, meaning number of 64-bit storage words (power of 2).
REQ-005 SHALL have port ACLK  input  1  meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port ARESETn  input  1  meaning asynchronous active-low reset.
REQ-007 SHALL have ports AWID_a/AWADDR_a/AWLEN_a/AWSIZE_a/AWBURST_a/AWVALID_a  input  id_wid/adr_wid/8/3/2/1  meaning write address channel.
REQ-008 SHALL have ports AWLOCK_a/AWCACHE_a/AWPROT_a and ARLOCK_a/ARCACHE_a/ARPROT_a  input  2/2/3 each  meaning sideband, accepted and ignored.
REQ-009 SHALL have port AWREADY_a  output  1  meaning write address accepted.
REQ-010 SHALL have ports WID_a/WDATA_a/WSTRB_a/WLAST_a/WVALID_a  input  id_wid/data_wid/data_wid/8/1/1  meaning write data channel.
REQ-011 SHALL have port WREADY_a  output  1; BID_a/BRESP_a/BVALID_a  output  id_wid/2/1; BREADY_a  input  1  meaning write response channel.
REQ-012 SHALL have ports ARID_a/ARADDR_a/ARLEN_a/ARSIZE_a/ARBURST_a/ARVALID_a  input  as AW; ARREADY_a  output  1  meaning read address channel.
REQ-013 SHALL have ports RID_a/RDATA_a/RRESP_a/RLAST_a/RVALID_a  output  id_wid/data_wid/2/1/1; RREADY_a  input  1  meaning read data channel.

Function
REQ-014 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; AWREADY_a=1 only in W_IDLE; AW handshake captures ID/addr/len/size/burst and moves to W_DATA next cycle.
REQ-015 In W_DATA WREADY_a SHALL be 1; each W handshake writes bytes of word (addr[idx_msb:3] mod mem_depth) whose WSTRB_a bit is 1, advances address, increments beat counter.
REQ-016 W_DATA SHALL exit to W_RESP on the handshake where beat counter equals AWLEN; WLAST_a asserted on any other beat, or deasserted on that beat, sets sticky error -> BRESP_a=SLVERR(2'b10); WID_a is not checked.
REQ-017 In W_RESP BVALID_a=1, BID_a=captured AWID, BRESP_a OKAY(2'b00) or SLVERR; held stable until BREADY_a, then W_IDLE next cycle.
REQ-018 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY_a=1 only in R_IDLE; first RVALID_a asserted the cycle after AR handshake (1-cycle latency), RDATA_a registered.
REQ-019 In R_DATA RDATA_a/RID_a/RRESP_a/RLAST_a SHALL hold while RVALID_a=1 and RREADY_a=0; on handshake next beat is presented next cycle with no bubble; RLAST_a=1 only on beat ARLEN; after last handshake R_IDLE.
REQ-020 Address step SHALL be 8 for INCR(01), 0 for FIXED(00); AxSIZE other than 3 SHALL give SLVERR on every beat/response and suppress memory writes.
REQ-021 Read and write channels SHALL run concurrently; a read fetch and write of the same word in the same cycle returns pre-write data.
REQ-022 Address wrap beyond mem_depth SHALL be modulo mem_depth, no error.

Reset
REQ-023 ARESETn low SHALL immediately force both FSMs to IDLE and AWREADY_a, WREADY_a, BVALID_a, ARREADY_a, RVALID_a, RLAST_a, BRESP_a, RRESP_a, BID_a, RID_a, RDATA_a to 0; ARESETn low mid-burst abandons it without response.
REQ-024 Memory contents SHALL NOT be reset; first ready asserts the first cycle after ARESETn rises.

Configuration
REQ-025 Macro AXI_SLV_WRAP_EN defined: WRAP(10) bursts SHALL wrap at (len+1)*8-byte aligned boundary; len not in {1,3,7,15} -> SLVERR, writes suppressed.
REQ-026 Macro undefined: WRAP and reserved burst(11) SHALL return SLVERR, suppress writes, RDATA_a=0, full beat count still honoured.

Structure
REQ-027 Package axi4_slave_pkg SHALL hold RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP constants and write/read state enums.
REQ-028 Sub-module axi4_slave_addr_gen SHALL compute next address from addr/len/burst/size, instantiated once per channel.

Verification
REQ-029 AW id=3 addr=0x10 len=3 INCR size=3, 4 beats WSTRB=FF data 1..4 WLAST on 4th -> BID=3 BRESP=00; AR same -> RDATA 1,2,3,4, RLAST on 4th, RID matches.
REQ-030 Write WSTRB=0x0F data 0xFFFF_FFFF_FFFF_FFFF over word 0 -> read returns 0x0000_0000_FFFF_FFFF.
REQ-031 len=3 with WLAST on beat 2 -> BRESP=10; RREADY toggled every cycle on len=7 read -> data held, 8 beats in order.
REQ-032 WRAP len=3 addr=0x18: macro on -> words 3,0,1,2 accessed, OKAY; macro off -> BRESP=10, memory unchanged.
REQ-033 ARESETn asserted during beat 2 of len=7 read -> RVALID=0 same cycle, ARREADY=1 first cycle after release, earlier memory data intact.
